// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch slice.
//   XLEN        : architectural register / address width
//   INST_BYTES  : size of one fetched instruction word in bytes
//   fetch_state_e : controller states (IDLE, FETCH, FLUSH)
//   NOP         : canonical ADDI x0,x0,0 encoding
//   align_pc()  : clears the two byte-offset bits of a PC
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl_if
// Groups the fetch controller's memory-side and decode-side handshakes.
//   mem_req / mem_addr / mem_gnt       : request/grant to instruction memory
//   mem_rvalid / mem_rdata             : in-order response words
//   redirect / redirect_pc             : restart request from branch resolution
//   inst_valid / inst_ready            : valid/ready toward decode
//   instruction / inst_pc              : head instruction and its address
// Modports: master = fetch controller, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface instr_fetch_ctrl_if;
   import riscv_pkg::*;

   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] inst_pc;

   modport master (
      output mem_req, mem_addr, inst_valid, instruction, inst_pc,
      input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  mem_req, mem_addr, inst_valid, instruction, inst_pc,
      output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
   );

endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Parameterized synchronous FIFO with flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, push_data : write one entry (ignored when full)
//   pop        : remove head entry (ignored when empty)
//   flush      : empties the FIFO, wins over push/pop
//   head_data  : oldest entry
//   count, empty, full : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (count_r == '0);
   assign full      = (count_r == CNT_W'(DEPTH));
   assign count     = count_r;
   assign head_data = mem_r[rd_ptr_r];
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction fetch sequencer: issues word fetches, buffers returned words
// with their PCs, presents them to decode, and handles redirects by flushing
// and discarding responses still in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_ctrl_if.master (memory + decode + redirect)
//   perf_stall_cycles : saturating stall counter, present only when the
//                       macro INSTR_FETCH_PERF_EN is defined
// Optional feature macro: INSTR_FETCH_PERF_EN
// ---------------------------------------------------------------------------
module instr_fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2,
   parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_ctrl_if.master bus
`ifdef INSTR_FETCH_PERF_EN
   ,
   output logic [31:0]        perf_stall_cycles
`endif
);

   // One extra bit so sums of two counters never wrap.
   localparam int SUM_W = CNT_W + 1;

   fetch_state_e    state_r;
   fetch_state_e    state_nx_s;
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] fetch_pc_nx_s;
   logic [CNT_W-1:0] drop_r;
   logic [CNT_W-1:0] drop_nx_s;
   logic            mem_req_r;
   logic            mem_req_nx_s;

   logic            grant_s;
   logic            rsp_legal_s;
   logic            proto_err_s;
   logic            push_s;
   logic            pop_s;
   logic            flush_s;
   logic            aq_push_s;
   logic            aq_pop_s;
   logic [SUM_W-1:0] inflight_s;
   logic [CNT_W-1:0] fifo_count_nx_s;
   logic [CNT_W-1:0] outstanding_nx_s;

   logic [2*XLEN-1:0] fifo_head_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;
   logic [XLEN-1:0]   aq_head_s;
   logic [CNT_W-1:0]  outstanding_s;
   logic              aq_empty_s;
   logic              aq_full_s;

   // Instruction buffer: {pc, word} per entry.
   fetch_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_inst_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data ({aq_head_s, bus.mem_rdata}),
      .pop       (pop_s),
      .flush     (flush_s),
      .head_data (fifo_head_s),
      .count     (fifo_count_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s)
   );

   // Address queue of granted-but-unanswered requests; its occupancy is the
   // outstanding counter and its head is the PC of the next response.
   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_addr_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (aq_push_s),
      .push_data (fetch_pc_r),
      .pop       (aq_pop_s),
      .flush     (flush_s),
      .head_data (aq_head_s),
      .count     (outstanding_s),
      .empty     (aq_empty_s),
      .full      (aq_full_s)
   );

   assign bus.mem_req     = mem_req_r;
   assign bus.mem_addr    = fetch_pc_r;
   assign bus.inst_valid  = ~fifo_empty_s;
   assign bus.instruction = fifo_empty_s ? 32'h0000_0000 : fifo_head_s[XLEN-1:0];
   assign bus.inst_pc     = fifo_empty_s ? 32'h0000_0000 : fifo_head_s[2*XLEN-1:XLEN];

   // next-state, counter and handshake decisions for this cycle
   always_comb begin
      grant_s     = mem_req_r & bus.mem_gnt;
      // A response is expected only if something is still in flight.
      rsp_legal_s = bus.mem_rvalid & ((drop_r != '0) | ~aq_empty_s);
      proto_err_s = bus.mem_rvalid & ~rsp_legal_s;

      push_s        = 1'b0;
      pop_s         = 1'b0;
      flush_s       = 1'b0;
      aq_push_s     = 1'b0;
      aq_pop_s      = 1'b0;
      fetch_pc_nx_s = fetch_pc_r;
      drop_nx_s     = drop_r;
      state_nx_s    = state_r;

      // Everything still owed by memory after this cycle, including a grant
      // taken now and less a response consumed now.
      inflight_s = SUM_W'(drop_r) + SUM_W'(outstanding_s) + SUM_W'(grant_s)
                   - SUM_W'(rsp_legal_s);

      if (bus.redirect) begin
         flush_s       = 1'b1;
         fetch_pc_nx_s = align_pc(bus.redirect_pc);
         drop_nx_s     = inflight_s[CNT_W-1:0];
         if (drop_nx_s != '0) begin
            state_nx_s = FLUSH;
         end else begin
            state_nx_s = FETCH;
         end
      end else begin
         pop_s = ~fifo_empty_s & bus.inst_ready;

         if (grant_s) begin
            aq_push_s     = ~aq_full_s;
            fetch_pc_nx_s = fetch_pc_r + XLEN'(INST_BYTES);
         end else begin
            aq_push_s     = 1'b0;
            fetch_pc_nx_s = fetch_pc_r;
         end

         if (bus.mem_rvalid && (drop_r != '0)) begin
            drop_nx_s = drop_r - CNT_W'(1);
         end else if (rsp_legal_s) begin
            push_s   = ~fifo_full_s;
            aq_pop_s = 1'b1;
         end else begin
            // no response, or one with nothing in flight: ignored
            drop_nx_s = drop_r;
         end

         case (state_r)
            IDLE:    state_nx_s = FETCH;
            FETCH:   state_nx_s = FETCH;
            FLUSH: begin
               if (drop_nx_s == '0) begin
                  state_nx_s = FETCH;
               end else begin
                  state_nx_s = FLUSH;
               end
            end
            default: state_nx_s = IDLE;
         endcase
      end

      if (flush_s) begin
         fifo_count_nx_s = '0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   fifo_count_nx_s = fifo_count_s + CNT_W'(1);
            2'b01:   fifo_count_nx_s = fifo_count_s - CNT_W'(1);
            default: fifo_count_nx_s = fifo_count_s;
         endcase
      end

      if (flush_s) begin
         outstanding_nx_s = '0;
      end else begin
         case ({aq_push_s, aq_pop_s})
            2'b10:   outstanding_nx_s = outstanding_s + CNT_W'(1);
            2'b01:   outstanding_nx_s = outstanding_s - CNT_W'(1);
            default: outstanding_nx_s = outstanding_s;
         endcase
      end

      // Request is registered from next-cycle occupancy so that it equals
      // the issue rule evaluated on the registered state.
      mem_req_nx_s = (state_nx_s == FETCH) &&
                     ((SUM_W'(fifo_count_nx_s) + SUM_W'(outstanding_nx_s))
                      < SUM_W'(FIFO_DEPTH));
   end

   // controller state, fetch PC, drop counter and request register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         drop_r     <= '0;
         mem_req_r  <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         fetch_pc_r <= fetch_pc_nx_s;
         drop_r     <= drop_nx_s;
         mem_req_r  <= mem_req_nx_s;
      end
   end

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] perf_r;

   // saturating count of cycles where decode is starved or fetch is flushing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_r <= 32'h0000_0000;
      end else if ((((state_r == FETCH) && fifo_empty_s) || (state_r == FLUSH)) &&
                   (perf_r != 32'hFFFF_FFFF)) begin
         perf_r <= perf_r + 32'h0000_0001;
      end else begin
         perf_r <= perf_r;
      end
   end

   assign perf_stall_cycles = perf_r;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
// Directed self-checking bench for instr_fetch_ctrl (FIFO_DEPTH = 2).
// Memory words are addr ^ 32'hCAFE_0013 when the bench auto-responds.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;
   import riscv_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp  = 0;
   int n_bad  = 0;
   int grants = 0;
   bit auto_mem = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_ctrl_if bus();

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] perf;
`endif

   instr_fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef INSTR_FETCH_PERF_EN
      ,
      .perf_stall_cycles (perf)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hCAFE_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sample on the falling edge, return 1 time unit after the next rising edge.
   task automatic tick();
      logic        g;
      logic [31:0] a;
      logic [31:0] occ;
      @(negedge clk);
      g   = bus.mem_req & bus.mem_gnt;
      a   = bus.mem_addr;
      occ = 32'(dut.fifo_count_s) + 32'(dut.outstanding_s);
      chk("occupancy_le_depth", 32'(occ <= 32'd2), 32'd1);
      if (g) grants++;
      @(posedge clk);
      #1;
      if (auto_mem) begin
         bus.mem_rvalid = g;
         bus.mem_rdata  = g ? mem_word(a) : 32'h0000_0000;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   32'(bus.mem_req),    32'd0);
      chk({tag, "_addr"},  bus.mem_addr,        32'h0000_0000);
      chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
      chk({tag, "_inst"},  bus.instruction,     32'h0000_0000);
      chk({tag, "_pc"},    bus.inst_pc,         32'h0000_0000);
   endtask

   // Leaves the bench one unit after the edge where reset was released.
   task automatic do_reset();
      rst_n           = 1'b0;
      auto_mem        = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0000_0000;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = 32'h0000_0000;
      tick();
      chk_reset_outputs("reset");
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mem_gnt     = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = 32'h0000_0000;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0000_0000;
      bus.inst_ready  = 1'b0;

      // ---- T1: zero-wait streaming ----
      do_reset();
      bus.mem_gnt = 1'b1; bus.inst_ready = 1'b1; auto_mem = 1'b1;
      chk("t1_idle_req", 32'(bus.mem_req), 32'd0);
      tick();
      chk("t1_c1_req",   32'(bus.mem_req), 32'd1);
      chk("t1_c1_addr",  bus.mem_addr, 32'h0000_0000);
      chk("t1_c1_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      chk("t1_c2_addr",  bus.mem_addr, 32'h0000_0004);
      tick();
      chk("t1_c3_valid", 32'(bus.inst_valid), 32'd1);
      chk("t1_c3_pc",    bus.inst_pc, 32'h0000_0000);
      chk("t1_c3_inst",  bus.instruction, 32'hCAFE_0013);
      chk("t1_c3_req",   32'(bus.mem_req), 32'd0);
      tick();
      chk("t1_c4_pc",    bus.inst_pc, 32'h0000_0004);
      chk("t1_c4_inst",  bus.instruction, 32'hCAFE_0017);
      chk("t1_c4_addr",  bus.mem_addr, 32'h0000_0008);
      chk("t1_c4_req",   32'(bus.mem_req), 32'd1);
      tick();
      chk("t1_c5_valid", 32'(bus.inst_valid), 32'd0);
      chk("t1_c5_addr",  bus.mem_addr, 32'h0000_000C);
      tick();
      chk("t1_c6_pc",    bus.inst_pc, 32'h0000_0008);
      chk("t1_c6_inst",  bus.instruction, 32'hCAFE_001B);

      // ---- T2: decode back-pressure ----
      do_reset();
      bus.mem_gnt = 1'b1; bus.inst_ready = 1'b0; auto_mem = 1'b1;
      grants = 0;
      for (int i = 0; i < 12; i++) tick();
      chk("t2_grants",   32'(grants), 32'd2);
      chk("t2_req_off",  32'(bus.mem_req), 32'd0);
      chk("t2_head_pc",  bus.inst_pc, 32'h0000_0000);
      chk("t2_head_inst", bus.instruction, 32'hCAFE_0013);
      bus.inst_ready = 1'b1;
      tick();
      chk("t2_next_pc",  bus.inst_pc, 32'h0000_0004);
      chk("t2_next_inst", bus.instruction, 32'hCAFE_0017);
      tick();
      chk("t2_drained",  32'(bus.inst_valid), 32'd0);

      // ---- T3: grant withheld ----
      do_reset();
      bus.mem_gnt = 1'b0; bus.inst_ready = 1'b1; auto_mem = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_req",  32'(bus.mem_req), 32'd1);
         chk("t3_hold_addr", bus.mem_addr, 32'h0000_0000);
         tick();
      end
      bus.mem_gnt = 1'b1;
      tick();
      chk("t3_resume_addr", bus.mem_addr, 32'h0000_0004);
      tick();
      chk("t3_resume_pc",   bus.inst_pc, 32'h0000_0000);
      chk("t3_resume_inst", bus.instruction, 32'hCAFE_0013);

      // ---- T4: redirect with two responses outstanding ----
      do_reset();
      bus.mem_gnt = 1'b1; bus.inst_ready = 1'b1; auto_mem = 1'b0;
      tick();
      tick();
      tick();
      chk("t4_req_full", 32'(bus.mem_req), 32'd0);
      chk("t4_outst",    32'(dut.outstanding_s), 32'd2);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
      tick();
      chk("t4_addr",     bus.mem_addr, 32'h0000_0100);
      chk("t4_req",      32'(bus.mem_req), 32'd0);
      chk("t4_flush",    32'(dut.state_r), 32'(FLUSH));
      bus.redirect = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_0001;
      tick();
      chk("t4_drop1_valid", 32'(bus.inst_valid), 32'd0);
      chk("t4_drop1_state", 32'(dut.state_r), 32'(FLUSH));
      bus.mem_rdata = 32'hDEAD_0002;
      tick();
      chk("t4_drop2_valid", 32'(bus.inst_valid), 32'd0);
      chk("t4_fetch_state", 32'(dut.state_r), 32'(FETCH));
      chk("t4_fetch_req",   32'(bus.mem_req), 32'd1);
      bus.mem_rvalid = 1'b0; auto_mem = 1'b1;
      tick();
      chk("t4_next_addr", bus.mem_addr, 32'h0000_0104);
      tick();
      chk("t4_first_pc",   bus.inst_pc, 32'h0000_0100);
      chk("t4_first_inst", bus.instruction, 32'hCAFE_0113);

      // ---- T5: redirect coinciding with response and pop ----
      do_reset();
      bus.mem_gnt = 1'b1; bus.inst_ready = 1'b0; auto_mem = 1'b1;
      tick();
      tick();
      tick();
      chk("t5_pre_valid", 32'(bus.inst_valid), 32'd1);
      chk("t5_pre_rvalid_outst", 32'(dut.outstanding_s), 32'd1);
      bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
      auto_mem = 1'b0;
      tick();
      chk("t5_valid",  32'(bus.inst_valid), 32'd0);
      chk("t5_addr",   bus.mem_addr, 32'h0000_0200);
      chk("t5_state",  32'(dut.state_r), 32'(FETCH));
      chk("t5_req",    32'(bus.mem_req), 32'd1);
      bus.redirect = 1'b0; bus.mem_rvalid = 1'b0; auto_mem = 1'b1;
      tick();
      chk("t5_next_addr", bus.mem_addr, 32'h0000_0204);
      tick();
      chk("t5_first_pc",   bus.inst_pc, 32'h0000_0200);
      chk("t5_first_inst", bus.instruction, 32'hCAFE_0213);

      // ---- T6: reset mid-stream ----
      do_reset();
      bus.mem_gnt = 1'b1; bus.inst_ready = 1'b1; auto_mem = 1'b0;
      tick();
      tick();
      chk("t6_outst", 32'(dut.outstanding_s), 32'd1);
      bus.mem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_async");
      tick();
      tick();
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t6_proto_flag", 32'(dut.proto_err_s), 32'd1);
      $display("note: response with nothing outstanding ignored (protocol error)");
      tick();
      chk("t6_stale_valid", 32'(bus.inst_valid), 32'd0);
      chk("t6_req",         32'(bus.mem_req), 32'd1);
      chk("t6_addr",        bus.mem_addr, 32'h0000_0000);
      bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1; auto_mem = 1'b1;
      tick();
      chk("t6_addr2", bus.mem_addr, 32'h0000_0004);
      tick();
      chk("t6_first_pc",   bus.inst_pc, 32'h0000_0000);
      chk("t6_first_inst", bus.instruction, 32'hCAFE_0013);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
